pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/pc_redirect_buf.sv | 25 ++
 rtl/pc_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared sequencer definitions: FSM state codes, PC step and the redirect record.
// Latency: none (constants, types and a pure function only).
// Backpressure: not applicable.
package cpu_pkg;

    // FSM state encoding, also exported on state_o
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    // Sequential fetch step in bytes
    localparam logic [31:0] PC_INC = 32'd4;

    // Width of the mem-stall cycle counter (MAX_WAIT tops out at 255)
    localparam int WAIT_CNT_W = 8;

    // A redirect target together with its valid flag
    typedef struct packed {
        logic        vld;
        logic [31:0] dat;
    } redirect_t;

    // Sequential next PC; wraps modulo 2^32
    function automatic logic [31:0] pc_seq_inc(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending redirect target, captured while the pipe is frozen by a memory stall.
// Latency: capture visible the cycle after cap.vld; clear takes effect the following cycle.
// Backpressure: a valid entry is never overwritten; later captures are dropped until consumed or dropped.
module pc_redirect_buf
    import cpu_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      drop,
    input  logic      consume,
    input  redirect_t cap,
    output redirect_t pend
);

    // Hold the first redirect seen during a stall; release on consume, drop or reset
    always_ff @(posedge clk_i) begin
        if (rst_i || drop || consume) begin
            pend.vld <= 1'b0;
        end else if (cap.vld && !pend.vld) begin
            pend.vld <= 1'b1;
            pend.dat <= cap.dat;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection and pipeline stall/flush/bubble control for a 5-stage fetch front end.
// Latency: outputs combinational from state, pending target and inputs; state advances each posedge.
// Backpressure: mem_stall_i freezes PC and IF/ID; sticky timeout_o after MAX_WAIT stalled WAIT cycles.
// Optional PC_SEQ_PERF_EN adds saturating stall_cycles_o / redirect_cnt_o counters.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        hazard_i,
    input  logic        mem_stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic [31:0] pc_next_o,
    output logic        pc_stall_o,
    output logic        ifid_stall_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
    output logic [1:0]  state_o,
    output logic        timeout_o
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] redirect_cnt_o
`endif
);

    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic                  timeout_q;
    logic                  wait_stall;
    logic                  redir_vld;
    logic [31:0]           redir_tgt;
    logic                  consume;
    redirect_t             cap;
    redirect_t             pend;

    // Jump outranks branch when both resolve in the same cycle
    assign redir_vld = jump_i | branch_i;
    assign redir_tgt = jump_i ? jump_addr_i : branch_addr_i;

    // A stalled WAIT cycle is what the timeout counter measures
    assign wait_stall = (state_q == ST_WAIT) && mem_stall_i && start_i;

    assign state_o   = state_q;
    assign timeout_o = timeout_q;

    pc_redirect_buf u_redirect_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .drop    (!start_i),
        .consume (consume),
        .cap     (cap),
        .pend    (pend)
    );

    // Next-state and output decode; priority mem stall > hazard > jump > branch > sequential
    always_comb begin
        state_d       = state_q;
        pc_next_o     = pc_i;
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        cap           = '0;
        consume       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pc_next_o    = RESET_PC;
                pc_stall_o   = 1'b1;
                ifid_flush_o = 1'b1;
                state_d      = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (mem_stall_i) begin
                    pc_stall_o   = 1'b1;
                    ifid_stall_o = 1'b1;
                    cap.vld      = redir_vld;
                    cap.dat      = redir_tgt;
                    state_d      = ST_WAIT;
                end else if (hazard_i && (state_q == ST_RUN)) begin
                    // The stalled ID instruction is re-evaluated in HOLD, so its redirect waits too
                    pc_stall_o    = 1'b1;
                    ifid_stall_o  = 1'b1;
                    idex_bubble_o = 1'b1;
                    state_d       = ST_HOLD;
                end else begin
                    pc_next_o    = redir_vld ? redir_tgt : pc_seq_inc(pc_i);
                    ifid_flush_o = redir_vld;
                    state_d      = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (mem_stall_i) begin
                    pc_stall_o   = 1'b1;
                    ifid_stall_o = 1'b1;
                    cap.vld      = redir_vld;
                    cap.dat      = redir_tgt;
                end else begin
                    // Exit cycle: a redirect captured during the stall takes precedence
                    consume = pend.vld;
                    if (pend.vld) begin
                        pc_next_o    = pend.dat;
                        ifid_flush_o = 1'b1;
                    end else begin
                        pc_next_o    = redir_vld ? redir_tgt : pc_seq_inc(pc_i);
                        ifid_flush_o = redir_vld;
                    end
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!start_i) begin
            state_d = ST_IDLE;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stalled-cycle counter (cleared outside WAIT) and sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else if (wait_stall) begin
            if (wait_cnt_q != MAX_WAIT_C) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (wait_cnt_q >= (MAX_WAIT_C - 1'b1)) begin
                timeout_q <= 1'b1;
            end
        end else begin
            wait_cnt_q <= '0;
        end
    end

`ifdef PC_SEQ_PERF_EN
    // Saturating counts of stall cycles and taken redirect flushes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_o <= '0;
            redirect_cnt_o <= '0;
        end else begin
            if (((state_q == ST_HOLD) || (state_q == ST_WAIT)) && (stall_cycles_o != '1)) begin
                stall_cycles_o <= stall_cycles_o + 1'b1;
            end
            if (ifid_flush_o && (state_q != ST_IDLE) && (redirect_cnt_o != '1)) begin
                redirect_cnt_o <= redirect_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a reference model.
// Latency: compares outputs at the falling edge for inputs applied just after the rising edge.
// Backpressure: long mem-stall bursts exercise WAIT, the pending target and the sticky timeout.
module tb_pc_sequencer;

    localparam int          MAXW = 4;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, hazard_i, mem_stall_i, branch_i, jump_i;
    logic [31:0] pc_i, branch_addr_i, jump_addr_i;
    logic [31:0] pc_next_o;
    logic        pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, timeout_o;
    logic [1:0]  state_o;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] stall_cycles_o, redirect_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0=IDLE 1=RUN 2=HOLD 3=WAIT, pending target queue, stalled WAIT cycle count
    int          m_mode = 0;
    logic [31:0] m_pend[$];
    int          m_wait = 0;
    bit          m_to   = 1'b0;

    logic [31:0] e_pc;
    logic        e_pst, e_ist, e_fl, e_bub, e_care;
    logic [38:0] exp_v, obs_v;

    pc_sequencer #(.RESET_PC(RPC), .MAX_WAIT(MAXW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .pc_i          (pc_i),
        .hazard_i      (hazard_i),
        .mem_stall_i   (mem_stall_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .jump_i        (jump_i),
        .jump_addr_i   (jump_addr_i),
        .pc_next_o     (pc_next_o),
        .pc_stall_o    (pc_stall_o),
        .ifid_stall_o  (ifid_stall_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_bubble_o (idex_bubble_o),
        .state_o       (state_o),
        .timeout_o     (timeout_o)
`ifdef PC_SEQ_PERF_EN
        ,
        .stall_cycles_o(stall_cycles_o),
        .redirect_cnt_o(redirect_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task set_in(input logic r, input logic s, input logic [31:0] pc, input logic hz, input logic ms,
                input logic j, input logic [31:0] ja, input logic b, input logic [31:0] ba);
        rst_i = r; start_i = s; pc_i = pc; hazard_i = hz; mem_stall_i = ms;
        jump_i = j; jump_addr_i = ja; branch_i = b; branch_addr_i = ba;
    endtask

    // Expected outputs for the current model state and inputs, then the observed vector
    task sample();
        @(negedge clk_i);
        e_pst = 1'b0; e_ist = 1'b0; e_fl = 1'b0; e_bub = 1'b0; e_pc = pc_i;
        if (m_mode == 0) begin
            e_pc = RPC; e_pst = 1'b1; e_fl = 1'b1;
        end else if (mem_stall_i) begin
            e_pst = 1'b1; e_ist = 1'b1;
        end else if (m_mode == 1 && hazard_i) begin
            e_pst = 1'b1; e_ist = 1'b1; e_bub = 1'b1;
        end else if (m_mode == 3 && m_pend.size() != 0) begin
            e_pc = m_pend[0]; e_fl = 1'b1;
        end else if (jump_i) begin
            e_pc = jump_addr_i; e_fl = 1'b1;
        end else if (branch_i) begin
            e_pc = branch_addr_i; e_fl = 1'b1;
        end else begin
            e_pc = pc_i + 32'd4;
        end
        // While the PC register is held (outside IDLE) the next-PC value is a don't-care
        e_care = (m_mode == 0) || !e_pst;
        exp_v = {2'(m_mode), e_pst, e_ist, e_fl, e_bub, m_to, e_care ? e_pc : 32'h0};
        obs_v = {state_o, pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, timeout_o,
                 e_care ? pc_next_o : 32'h0};
    endtask

    // Update the model as the clock edge will, then move past that edge
    task advance();
        if (rst_i) begin
            m_mode = 0; m_pend.delete(); m_wait = 0; m_to = 1'b0;
        end else if (!start_i) begin
            m_mode = 0; m_pend.delete(); m_wait = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (mem_stall_i) begin
            if ((jump_i || branch_i) && m_pend.size() == 0)
                m_pend.push_back(jump_i ? jump_addr_i : branch_addr_i);
            if (m_mode == 3) begin
                m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
                if (m_wait >= MAXW) m_to = 1'b1;
            end
            m_mode = 3;
        end else if (m_mode == 1 && hazard_i) begin
            m_mode = 2;
        end else begin
            m_pend.delete(); m_wait = 0; m_mode = 1;
        end
        @(posedge clk_i);
        #1;
    endtask

    // Reset, then one IDLE cycle so the sequencer is in RUN
    task go_run();
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0); advance();
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0); advance();
    endtask

    task test_reset();
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0); advance();
        sample();
        checks++; if (obs_v !== exp_v) begin failures++; $display("FAIL reset_vec got=%h exp=%h", obs_v, exp_v); end
        checks++; if (state_o !== 2'd0 || timeout_o !== 1'b0) begin failures++; $display("FAIL reset_state state=%0d timeout=%0b exp 0/0", state_o, timeout_o); end
        advance();
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        sample();
        checks++; if (pc_next_o !== 32'h0 || pc_stall_o !== 1'b1) begin failures++; $display("FAIL idle_first pc=%h stall=%0b exp 0/1", pc_next_o, pc_stall_o); end
        advance();
        sample();
        checks++; if (state_o !== 2'd1 || pc_next_o !== 32'h4) begin failures++; $display("FAIL run_first state=%0d pc=%h exp 1/4", state_o, pc_next_o); end
        checks++; if (obs_v !== exp_v) begin failures++; $display("FAIL run_first_vec got=%h exp=%h", obs_v, exp_v); end
        advance();
    endtask

    task test_hazard();
        go_run();
        set_in(0, 1, 32'h100, 1, 0, 1, 32'h700, 0, 0);
        sample();
        checks++; if (pc_stall_o !== 1'b1 || idex_bubble_o !== 1'b1 || ifid_flush_o !== 1'b0) begin failures++; $display("FAIL hazard_stall stall=%0b bubble=%0b flush=%0b exp 1/1/0", pc_stall_o, idex_bubble_o, ifid_flush_o); end
        advance();
        set_in(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
        sample();
        checks++; if (state_o !== 2'd2 || pc_next_o !== 32'h104 || pc_stall_o !== 1'b0) begin failures++; $display("FAIL hazard_hold state=%0d pc=%h stall=%0b exp 2/104/0", state_o, pc_next_o, pc_stall_o); end
        advance();
    endtask

    task test_priority();
        set_in(0, 1, 32'h104, 0, 0, 1, 32'h300, 1, 32'h200);
        sample();
        checks++; if (pc_next_o !== 32'h300 || ifid_flush_o !== 1'b1) begin failures++; $display("FAIL jump_over_branch pc=%h flush=%0b exp 300/1", pc_next_o, ifid_flush_o); end
        advance();
        set_in(0, 1, 32'h300, 0, 0, 0, 0, 1, 32'h200);
        sample();
        checks++; if (pc_next_o !== 32'h200 || ifid_flush_o !== 1'b1) begin failures++; $display("FAIL branch_taken pc=%h flush=%0b exp 200/1", pc_next_o, ifid_flush_o); end
        advance();
    endtask

    task test_mem_redirect();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 32'h80, 0, 1, 0, 0, 1, 32'h40);
            sample();
            checks++; if (pc_stall_o !== 1'b1 || ifid_stall_o !== 1'b1 || ifid_flush_o !== 1'b0) begin failures++; $display("FAIL memstall_c%0d pstall=%0b istall=%0b flush=%0b exp 1/1/0", i, pc_stall_o, ifid_stall_o, ifid_flush_o); end
            advance();
        end
        set_in(0, 1, 32'h80, 0, 0, 0, 0, 0, 0);
        sample();
        checks++; if (pc_next_o !== 32'h40 || ifid_flush_o !== 1'b1 || pc_stall_o !== 1'b0) begin failures++; $display("FAIL memstall_exit pc=%h flush=%0b stall=%0b exp 40/1/0", pc_next_o, ifid_flush_o, pc_stall_o); end
        advance();
        set_in(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
        sample();
        checks++; if (pc_next_o !== 32'h44 || ifid_flush_o !== 1'b0) begin failures++; $display("FAIL pend_cleared pc=%h flush=%0b exp 44/0", pc_next_o, ifid_flush_o); end
        advance();
    endtask

    task test_no_overwrite();
        set_in(0, 1, 32'h44, 0, 1, 1, 32'h500, 0, 0); advance();
        set_in(0, 1, 32'h44, 0, 1, 0, 0, 1, 32'h600); advance();
        advance();
        set_in(0, 1, 32'h44, 0, 0, 0, 0, 0, 0);
        sample();
        checks++; if (pc_next_o !== 32'h500 || ifid_flush_o !== 1'b1) begin failures++; $display("FAIL pend_keep pc=%h flush=%0b exp 500/1", pc_next_o, ifid_flush_o); end
        advance();
    endtask

    task test_timeout();
        go_run();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1, 32'h20, 0, 1, 0, 0, 0, 0);
            sample();
            checks++; if (timeout_o !== (i >= 5)) begin failures++; $display("FAIL timeout_c%0d got=%0b exp=%0b", i, timeout_o, (i >= 5)); end
            checks++; if (obs_v !== exp_v) begin failures++; $display("FAIL timeout_vec_c%0d got=%h exp=%h", i, obs_v, exp_v); end
            advance();
        end
        set_in(0, 1, 32'h20, 0, 0, 0, 0, 0, 0); advance();
        set_in(0, 0, 32'h20, 0, 0, 0, 0, 0, 0); advance();
        sample();
        checks++; if (timeout_o !== 1'b1 || state_o !== 2'd0) begin failures++; $display("FAIL timeout_sticky timeout=%0b state=%0d exp 1/0", timeout_o, state_o); end
        set_in(1, 1, 32'h20, 0, 0, 0, 0, 0, 0); advance();
        sample();
        checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL timeout_reset got=%0b exp=0", timeout_o); end
        advance();
    endtask

    task test_wrap_and_reset_mid_wait();
        go_run();
        set_in(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        sample();
        checks++; if (pc_next_o !== 32'h0 || ifid_flush_o !== 1'b0) begin failures++; $display("FAIL pc_wrap pc=%h flush=%0b exp 0/0", pc_next_o, ifid_flush_o); end
        advance();
        set_in(0, 1, 32'h10, 0, 1, 0, 0, 1, 32'h40); advance();
        set_in(0, 1, 32'h10, 0, 1, 0, 0, 0, 0); advance();
        set_in(1, 1, 32'h10, 0, 1, 0, 0, 0, 0); advance();
        set_in(0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
        sample();
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_mid_wait state=%0d exp 0", state_o); end
        advance();
        set_in(0, 1, 32'h10, 0, 1, 0, 0, 0, 0); advance();
        set_in(0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
        sample();
        checks++; if (pc_next_o !== 32'h14 || ifid_flush_o !== 1'b0) begin failures++; $display("FAIL pend_dropped pc=%h flush=%0b exp 14/0", pc_next_o, ifid_flush_o); end
        advance();
    endtask

    task test_random();
        logic ms;
        ms = 1'b0;
        go_run();
        for (int n = 0; n < 3000; n++) begin
            ms = ($urandom_range(0, 99) < (ms ? 80 : 25));
            set_in(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 95),
                   ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC),
                   ($urandom_range(0, 99) < 20), ms,
                   ($urandom_range(0, 99) < 20), $urandom() & 32'hFFFF_FFFC,
                   ($urandom_range(0, 99) < 30), $urandom() & 32'hFFFF_FFFC);
            sample();
            checks++; if (obs_v !== exp_v) begin failures++; $display("FAIL random_n%0d got=%h exp=%h", n, obs_v, exp_v); end
            advance();
        end
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_hazard();
        test_priority();
        test_mem_redirect();
        test_no_overwrite();
        test_timeout();
        test_wrap_and_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
